// File: rtl/lsu_ctrl.sv
// Load/store control stage in front of the 8-word data memory: computes and range-checks
// the effective address, strobes the memory, and returns load data over a valid/ready handshake.
module lsu_ctrl #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 8,
    parameter int MEM_DEPTH = 8,
    parameter int REG_W     = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_is_store,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W-1:0] offset,
    input  logic [DATA_W-1:0] store_data,
    input  logic [REG_W-1:0]  dest_reg,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] write_data,
    input  logic [DATA_W-1:0] read_data,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [DATA_W-1:0] wb_data,
    output logic [REG_W-1:0]  wb_dest,
    output logic              addr_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_STORE,
        S_LOAD,
        S_CAPTURE,
        S_RESP
    } state_t;

    state_t             r_state;
    logic               r_req_ready;
    logic               r_mem_read;
    logic               r_mem_write;
    logic [ADDR_W-1:0]  r_addr;
    logic [DATA_W-1:0]  r_write_data;
    logic               r_wb_valid;
    logic [DATA_W-1:0]  r_wb_data;
    logic [REG_W-1:0]   r_wb_dest;
    logic               r_addr_err;

    logic [ADDR_W-1:0]  w_eff;
    logic               w_in_range;

    // Carry out of the address add is intentionally dropped (wrap-around addressing).
    assign w_eff      = base + offset;
    assign w_in_range = (w_eff < ADDR_W'(MEM_DEPTH));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_req_ready  <= 1'b1;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_addr       <= '0;
            r_write_data <= '0;
            r_wb_valid   <= 1'b0;
            r_wb_data    <= '0;
            r_wb_dest    <= '0;
            r_addr_err   <= 1'b0;
        end else begin
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_addr_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_addr       <= w_eff;
                        r_write_data <= store_data;
                        r_wb_dest    <= dest_reg;
                        if (!w_in_range) begin
                            r_addr_err <= 1'b1;
                        end else if (req_is_store) begin
                            r_state     <= S_STORE;
                            r_mem_write <= 1'b1;
                            r_req_ready <= 1'b0;
                        end else begin
                            r_state     <= S_LOAD;
                            r_mem_read  <= 1'b1;
                            r_req_ready <= 1'b0;
                        end
                    end
                end
                S_STORE: begin
                    r_state     <= S_IDLE;
                    r_req_ready <= 1'b1;
                end
                S_LOAD: begin
                    r_state <= S_CAPTURE;
                end
                // read_data was refreshed by the memory on the edge that ended LOAD.
                S_CAPTURE: begin
                    r_wb_data  <= read_data;
                    r_wb_valid <= 1'b1;
                    r_state    <= S_RESP;
                end
                S_RESP: begin
                    if (wb_ready) begin
                        r_wb_valid  <= 1'b0;
                        r_state     <= S_IDLE;
                        r_req_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_req_ready <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready  = r_req_ready;
    assign mem_read   = r_mem_read;
    assign mem_write  = r_mem_write;
    assign addr       = r_addr;
    assign write_data = r_write_data;
    assign wb_valid   = r_wb_valid;
    assign wb_data    = r_wb_data;
    assign wb_dest    = r_wb_dest;
    assign addr_err   = r_addr_err;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: directed scenarios plus randomized requests checked against a
// transaction-level memory model.
module tb_lsu_ctrl;

    logic       clk;
    logic       reset;
    logic       req_valid;
    logic       req_ready;
    logic       req_is_store;
    logic [7:0] base;
    logic [7:0] offset;
    logic [7:0] store_data;
    logic [2:0] dest_reg;
    logic       mem_read;
    logic       mem_write;
    logic [7:0] addr;
    logic [7:0] write_data;
    logic [7:0] read_data;
    logic       wb_valid;
    logic       wb_ready;
    logic [7:0] wb_data;
    logic [2:0] wb_dest;
    logic       addr_err;

    int n_chk  = 0;
    int n_fail = 0;

    logic [7:0] mem     [0:7];
    logic [7:0] ref_mem [0:7];

    lsu_ctrl #(.DATA_W(8), .ADDR_W(8), .MEM_DEPTH(8), .REG_W(3)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
        .base(base), .offset(offset), .store_data(store_data), .dest_reg(dest_reg),
        .mem_read(mem_read), .mem_write(mem_write), .addr(addr), .write_data(write_data),
        .read_data(read_data),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data), .wb_dest(wb_dest),
        .addr_err(addr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory environment: clocked write, clocked read into read_data.
    always @(posedge clk) begin
        if (mem_write) mem[addr[2:0]] <= write_data;
        if (mem_read)  read_data <= mem[addr[2:0]];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (reset) chk("rw_exclusive", {31'd0, mem_read & mem_write}, 32'd0);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request from IDLE and check every cycle until the block is idle again.
    task automatic do_req(input logic st, input logic [7:0] b, input logic [7:0] o,
                          input logic [7:0] sd, input logic [2:0] dr, input int stall);
        logic [7:0] eff;
        logic [7:0] exp_d;
        eff = b + o;
        chk("ready_idle", req_ready, 1);
        req_valid = 1'b1; req_is_store = st; base = b; offset = o;
        store_data = sd; dest_reg = dr; wb_ready = 1'b0;
        tick();
        req_valid = 1'b0;
        chk("addr_latch", addr, eff);
        chk("dest_latch", wb_dest, dr);
        if (eff >= 8) begin
            chk("err_pulse", addr_err, 1);
            chk("err_no_rd", mem_read, 0);
            chk("err_no_wr", mem_write, 0);
            chk("err_ready", req_ready, 1);
            tick();
            chk("err_drop", addr_err, 0);
            chk("err_no_wb", wb_valid, 0);
            chk("err_no_rd2", mem_read, 0);
        end else if (st) begin
            chk("st_wr", mem_write, 1);
            chk("st_no_rd", mem_read, 0);
            chk("st_wdata", write_data, sd);
            chk("st_busy", req_ready, 0);
            chk("st_no_err", addr_err, 0);
            tick();
            ref_mem[eff[2:0]] = sd;
            chk("st_wr_drop", mem_write, 0);
            chk("st_ready", req_ready, 1);
            chk("st_no_wb", wb_valid, 0);
            chk("st_mem", mem[eff[2:0]], ref_mem[eff[2:0]]);
        end else begin
            exp_d = ref_mem[eff[2:0]];
            chk("ld_rd", mem_read, 1);
            chk("ld_no_wr", mem_write, 0);
            chk("ld_busy", req_ready, 0);
            chk("ld_no_err", addr_err, 0);
            tick();
            chk("ld_rd_drop", mem_read, 0);
            chk("ld_no_wb_early", wb_valid, 0);
            tick();
            chk("ld_wb_valid", wb_valid, 1);
            chk("ld_wb_data", wb_data, exp_d);
            chk("ld_wb_dest", wb_dest, dr);
            wb_ready = (stall == 0);
            for (int k = 0; k < stall; k++) begin
                req_valid = 1'b1; req_is_store = 1'($urandom);
                base = 8'($urandom); offset = 8'($urandom);
                store_data = 8'($urandom); dest_reg = 3'($urandom);
                tick();
                chk("stall_valid", wb_valid, 1);
                chk("stall_data", wb_data, exp_d);
                chk("stall_dest", wb_dest, dr);
                chk("stall_busy", req_ready, 0);
                chk("stall_addr", addr, eff);
                chk("stall_no_rd", mem_read, 0);
            end
            req_valid = 1'b0;
            wb_ready = 1'b1;
            tick();
            chk("wb_drop", wb_valid, 0);
            chk("wb_ready_back", req_ready, 1);
            wb_ready = 1'b0;
        end
    endtask

    initial begin
        logic [7:0] e;
        logic [7:0] o;
        for (int i = 0; i < 8; i++) begin
            mem[i]     = 8'(i);
            ref_mem[i] = 8'(i);
        end
        read_data = 8'h00;
        reset = 1'b0; req_valid = 1'b0; req_is_store = 1'b0;
        base = 8'h00; offset = 8'h00; store_data = 8'h00; dest_reg = 3'd0; wb_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", req_ready, 1);
        chk("rst_rd", mem_read, 0);
        chk("rst_wr", mem_write, 0);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_err", addr_err, 0);
        chk("rst_addr", addr, 0);
        chk("rst_wdata", write_data, 0);
        chk("rst_wb_data", wb_data, 0);
        chk("rst_wb_dest", wb_dest, 0);
        @(negedge clk);
        reset = 1'b1;
        tick();

        // Basic load, store-then-load, wrap-around, out-of-range, stalled writeback.
        do_req(1'b0, 8'd3, 8'd2, 8'h00, 3'd5, 0);
        do_req(1'b1, 8'd1, 8'd1, 8'hA5, 3'd0, 0);
        do_req(1'b0, 8'd0, 8'd2, 8'h00, 3'd1, 0);
        do_req(1'b1, 8'd2, 8'd0, 8'h02, 3'd0, 0);
        do_req(1'b0, 8'hFE, 8'h04, 8'h00, 3'd6, 0);
        do_req(1'b0, 8'd6, 8'd3, 8'h00, 3'd2, 0);
        do_req(1'b1, 8'd7, 8'd1, 8'h5A, 3'd0, 0);
        do_req(1'b0, 8'd4, 8'd3, 8'h00, 3'd7, 4);

        // Reset during CAPTURE discards the pending result.
        req_valid = 1'b1; req_is_store = 1'b0; base = 8'd1; offset = 8'd3; dest_reg = 3'd4;
        wb_ready = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        #1;
        reset = 1'b0;
        #1;
        chk("midrst_rd", mem_read, 0);
        chk("midrst_wb_valid", wb_valid, 0);
        chk("midrst_addr", addr, 0);
        chk("midrst_wb_data", wb_data, 0);
        chk("midrst_wb_dest", wb_dest, 0);
        chk("midrst_ready", req_ready, 1);
        @(negedge clk);
        reset = 1'b1;
        wb_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("postrst_no_wb", wb_valid, 0);
            chk("postrst_ready", req_ready, 1);
        end

        // Randomized traffic; most addresses chosen in range, some fully random.
        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(3) != 0) begin
                e = 8'($urandom_range(7));
                o = 8'($urandom);
                do_req(1'($urandom), e - o, o, 8'($urandom), 3'($urandom),
                       int'($urandom_range(3)));
            end else begin
                do_req(1'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                       3'($urandom), int'($urandom_range(3)));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
